// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: packet-level receive controller behind usb_rx; validates PID, checks CRC5/CRC16,
// strips the data CRC and reports one result pulse per packet.
module usb_pkt_rx #(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic [3:0] pid,
  output logic       token_valid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic       hsk_valid,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       data_end,
  output logic       crc_ok,
  output logic       pkt_error
);
  localparam int CW = $clog2(MAX_PAYLOAD + 4);
  typedef enum logic [2:0] {IDLE, PID, TOK1, TOK2, TEND, DATA, HSK, DISCARD} state_t;
  state_t st, st_b;
  logic [7:0] pid_b, h0, h1;
  logic [15:0] tok, tok_n, crc16, crc16_n;
  logic [4:0] crc5, crc5_n;
  logic [CW-1:0] cnt, cnt_n;
  logic rst_q, tok_byte, dat_byte, pid_ok, is_tok, is_dat, is_hsk;
  function automatic logic [4:0] crc5_upd(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'h05 : 5'h00);
    return r;
  endfunction
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction
  assign pid_ok = pid_b[3:0] == ~pid_b[7:4];
  assign is_tok = pid_b[3:0] inside {4'b0001, 4'b1001, 4'b1101};
  assign is_dat = pid_b[3:0] inside {4'b0011, 4'b1011};
  assign is_hsk = pid_b[3:0] inside {4'b0010, 4'b1010, 4'b1110};
  // st_b is the state after consuming this cycle's byte, before end-of-packet is applied
  always_comb begin
    tok_byte = rx_valid && (st == TOK1 || st == TOK2);
    dat_byte = rx_valid && st == DATA;
    crc5_n = tok_byte ? crc5_upd(crc5, rx_data) : crc5;
    tok_n = tok_byte ? {rx_data, tok[15:8]} : tok;
    crc16_n = dat_byte ? crc16_upd(crc16, rx_data) : crc16;
    cnt_n = dat_byte ? cnt + CW'(1) : cnt;
    case (st)
      IDLE: st_b = (rx_active && rst_q) ? DISCARD : (rx_active && rx_valid) ? PID : IDLE;
      PID: st_b = !rx_active ? PID : !pid_ok ? DISCARD : is_tok ? TOK1 : is_dat ? DATA : is_hsk ? HSK : DISCARD;
      TOK1: st_b = rx_valid ? TOK2 : TOK1;
      TOK2: st_b = rx_valid ? TEND : TOK2;
      TEND, HSK: st_b = rx_valid ? DISCARD : st;
      DATA: st_b = (cnt_n > CW'(MAX_PAYLOAD + 2)) ? DISCARD : DATA;
      default: st_b = DISCARD;
    endcase
    if (rx_active && rx_error) st_b = DISCARD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      rst_q <= 1'b1;
      crc5 <= '1;
      crc16 <= '1;
      cnt <= '0;
      tok <= '0;
      pid_b <= '0;
      h0 <= '0;
      h1 <= '0;
      pid <= '0;
      token_addr <= '0;
      token_endp <= '0;
      out_data <= '0;
      {token_valid, hsk_valid, out_valid, data_end, crc_ok, pkt_error} <= '0;
    end else begin
      rst_q <= 1'b0;
      {token_valid, hsk_valid, out_valid, data_end, crc_ok, pkt_error} <= '0;
      crc5 <= crc5_n;
      crc16 <= crc16_n;
      cnt <= cnt_n;
      tok <= tok_n;
      st <= st_b;
      if (st == IDLE && rx_valid) pid_b <= rx_data;
      if (dat_byte && st_b == DATA) begin
        h0 <= h1;
        h1 <= rx_data;
        if (cnt >= CW'(2)) begin
          out_valid <= 1'b1;
          out_data <= h0;
        end
      end
      if (!rx_active && st != IDLE) begin
        st <= IDLE;
        crc5 <= '1;
        crc16 <= '1;
        cnt <= '0;
        case (st_b)
          TEND: if (crc5_n == 5'b01100) begin
            token_valid <= 1'b1;
            pid <= pid_b[3:0];
            token_addr <= tok_n[6:0];
            token_endp <= tok_n[10:7];
          end else pkt_error <= 1'b1;
          HSK: begin
            hsk_valid <= 1'b1;
            pid <= pid_b[3:0];
          end
          DATA: if (cnt_n < CW'(2)) pkt_error <= 1'b1;
          else begin
            data_end <= 1'b1;
            crc_ok <= crc16_n == 16'h800D;
            pid <= pid_b[3:0];
          end
          default: pkt_error <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_pkt_rx.sv
// tb_usb_pkt_rx: scoreboard bench; expected payload bytes and result pulses are queued as
// packets are driven and compared as the DUT produces them.
module tb_usb_pkt_rx;
  localparam int R_TOK = 0, R_HSK = 1, R_DAT = 2, R_ERR = 3;
  logic clk = 1'b0;
  logic reset = 1'b1, rx_active = 1'b0, rx_valid = 1'b0, rx_error = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] pid, token_endp;
  logic [6:0] token_addr;
  logic token_valid, hsk_valid, out_valid, data_end, crc_ok, pkt_error;
  logic [7:0] out_data;
  int checks = 0, errors = 0;
  logic [7:0] byte_q[$];
  int res_q[$];
  logic [7:0] pkt[$], pay[$];
  bit done = 1'b0;

  usb_pkt_rx #(.MAX_PAYLOAD(8)) dut (
    .clk(clk), .reset(reset), .rx_active(rx_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .pid(pid), .token_valid(token_valid), .token_addr(token_addr),
    .token_endp(token_endp), .hsk_valid(hsk_valid), .out_valid(out_valid), .out_data(out_data),
    .data_end(data_end), .crc_ok(crc_ok), .pkt_error(pkt_error)
  );

  always #5 clk = ~clk;

  // result codes are kind*2 + crc_ok (crc_ok only meaningful for data_end)
  task automatic monitor();
    int n, kind, got, exp;
    logic [7:0] eb;
    while (!done) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (byte_q.size() == 0) begin
          errors++;
          $display("FAIL out_data unexpected: got %h, expected no byte", out_data);
        end else begin
          eb = byte_q.pop_front();
          if (out_data !== eb) begin
            errors++;
            $display("FAIL out_data: got %h, expected %h", out_data, eb);
          end
        end
      end
      n = int'(token_valid) + int'(hsk_valid) + int'(data_end) + int'(pkt_error);
      if (n != 0) begin
        checks++;
        kind = token_valid ? R_TOK : hsk_valid ? R_HSK : data_end ? R_DAT : R_ERR;
        got = kind * 2 + ((kind == R_DAT) ? int'(crc_ok) : 0);
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL result unexpected: got code %0d, expected none", got);
        end else begin
          exp = res_q.pop_front();
          if (n != 1 || got !== exp) begin
            errors++;
            $display("FAIL result: got code %0d (%0d pulses), expected code %0d", got, n, exp);
          end
        end
      end
    end
  endtask

  task automatic drive_pkt();
    @(negedge clk) rx_active = 1'b1;
    @(negedge clk);
    foreach (pkt[i]) begin
      rx_valid = 1'b1;
      rx_data = pkt[i];
      @(negedge clk) rx_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    rx_active = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((res_q.size() != 0 || byte_q.size() != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (res_q.size() != 0 || byte_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results and %0d bytes pending, expected 0", name, res_q.size(), byte_q.size());
      res_q.delete();
      byte_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic build_data(input logic [7:0] p);
    logic [15:0] c = 16'hFFFF;
    foreach (pay[i]) for (int b = 0; b < 8; b++) c = (c[0] ^ pay[i][b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    c = ~c;
    pkt = {p};
    foreach (pay[i]) pkt.push_back(pay[i]);
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({pid, token_valid, token_addr, token_endp, hsk_valid, out_valid, out_data, data_end, crc_ok, pkt_error} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got pid=%h tok=%b hsk=%b ov=%b de=%b err=%b, expected all 0", pid, token_valid, hsk_valid, out_valid, data_end, pkt_error);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_setup_token();
    pkt = {8'h2D, 8'h00, 8'h10};
    res_q.push_back(R_TOK * 2);
    drive_pkt();
    wait_done("setup");
    checks++;
    if (pid !== 4'b1101 || token_addr !== 7'd0 || token_endp !== 4'd0) begin
      errors++;
      $display("FAIL setup fields: got pid=%b addr=%0d endp=%0d, expected 1101 0 0", pid, token_addr, token_endp);
    end
  endtask

  task automatic test_data0();
    pkt = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    for (int i = 1; i <= 8; i++) byte_q.push_back(pkt[i]);
    res_q.push_back(R_DAT * 2 + 1);
    drive_pkt();
    wait_done("data0");
    checks++;
    if (pid !== 4'b0011) begin
      errors++;
      $display("FAIL data0 pid: got %b, expected 0011", pid);
    end
    pkt[10] = 8'h95;
    for (int i = 1; i <= 8; i++) byte_q.push_back(pkt[i]);
    res_q.push_back(R_DAT * 2);
    drive_pkt();
    wait_done("data0 bad crc");
  endtask

  task automatic test_zero_len_ack();
    pkt = {8'h4B, 8'h00, 8'h00};
    res_q.push_back(R_DAT * 2 + 1);
    drive_pkt();
    wait_done("data1 empty");
    checks++;
    if (pid !== 4'b1011) begin
      errors++;
      $display("FAIL data1 pid: got %b, expected 1011", pid);
    end
    pkt = {8'hD2};
    res_q.push_back(R_HSK * 2);
    drive_pkt();
    wait_done("ack");
    checks++;
    if (pid !== 4'b0010) begin
      errors++;
      $display("FAIL ack pid: got %b, expected 0010", pid);
    end
  endtask

  task automatic test_bad_pid_short_token();
    pkt = {8'h3D};
    res_q.push_back(R_ERR * 2);
    drive_pkt();
    wait_done("bad pid");
    pkt = {8'h2D, 8'h00};
    res_q.push_back(R_ERR * 2);
    drive_pkt();
    wait_done("short token");
    pkt = {8'h2D, 8'h00, 8'h11};
    res_q.push_back(R_ERR * 2);
    drive_pkt();
    wait_done("token bad crc5");
    checks++;
    if (pid !== 4'b0010) begin
      errors++;
      $display("FAIL pid held after errors: got %b, expected 0010", pid);
    end
  endtask

  task automatic test_rx_error_oversize();
    @(negedge clk) rx_active = 1'b1;
    pkt = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00};
    byte_q.push_back(8'h80);
    res_q.push_back(R_ERR * 2);
    foreach (pkt[i]) begin
      if (i == 4) begin
        rx_error = 1'b1;
        @(negedge clk) rx_error = 1'b0;
      end
      rx_valid = 1'b1;
      rx_data = pkt[i];
      @(negedge clk) rx_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    rx_active = 1'b0;
    wait_done("rx_error");
    pay.delete();
    for (int i = 0; i < 11; i++) pay.push_back(8'(8'h11 * (i + 1)));
    build_data(8'hC3);
    for (int i = 0; i < 8; i++) byte_q.push_back(pay[i]);
    res_q.push_back(R_ERR * 2);
    drive_pkt();
    wait_done("oversize");
  endtask

  task automatic test_random_data();
    for (int k = 0; k < 4; k++) begin
      pay.delete();
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) pay.push_back(8'($urandom));
      build_data((k % 2 == 0) ? 8'hC3 : 8'h4B);
      foreach (pay[i]) byte_q.push_back(pay[i]);
      res_q.push_back(R_DAT * 2 + 1);
      drive_pkt();
      wait_done("random data");
    end
  endtask

  task automatic test_back_to_back();
    pkt = {8'hD2};
    res_q.push_back(R_HSK * 2);
    drive_pkt();
    pkt = {8'h2D, 8'h00, 8'h10};
    res_q.push_back(R_TOK * 2);
    drive_pkt();
    pkt = {8'h4B, 8'h00, 8'h00};
    res_q.push_back(R_DAT * 2 + 1);
    drive_pkt();
    wait_done("back to back");
  endtask

  task automatic test_reset_mid();
    @(negedge clk) rx_active = 1'b1;
    pkt = {8'hC3, 8'h80, 8'h06};
    foreach (pkt[i]) begin
      rx_valid = 1'b1;
      rx_data = pkt[i];
      @(negedge clk) rx_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h00;
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pid, token_valid, hsk_valid, out_valid, data_end, crc_ok, pkt_error} !== '0) begin
      errors++;
      $display("FAIL outputs during reset: got pid=%h ov=%b err=%b, expected 0", pid, out_valid, pkt_error);
    end
    reset = 1'b0;
    res_q.push_back(R_ERR * 2);
    pkt = {8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    foreach (pkt[i]) begin
      rx_valid = 1'b1;
      rx_data = pkt[i];
      @(negedge clk) rx_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    rx_active = 1'b0;
    wait_done("reset mid-packet");
    checks++;
    if (pid !== 4'b0000) begin
      errors++;
      $display("FAIL pid after reset: got %b, expected 0000", pid);
    end
    pkt = {8'hD2};
    res_q.push_back(R_HSK * 2);
    drive_pkt();
    wait_done("ack after reset");
    checks++;
    if (pid !== 4'b0010) begin
      errors++;
      $display("FAIL ack after reset pid: got %b, expected 0010", pid);
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        test_reset();
        test_setup_token();
        test_data0();
        test_zero_len_ack();
        test_bad_pid_short_token();
        test_rx_error_oversize();
        test_random_data();
        test_back_to_back();
        test_reset_mid();
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
